// File: rtl/pcm_transmitter.sv
// pcm_transmitter: serial PCM frame generator (sync word followed by FIFO data bytes).
// Each bit lasts 2*DIV clk_i cycles. The new bit is presented at baud count 0 together
// with the update level of txd_clk_o (~edge). The clock moves to the sampling level at
// count DIV. Data bytes are prefetched from a FIFO one bit period ahead of use; an empty
// FIFO substitutes 8'hFF and pulses underflow_o.
// Optional build macro PCM_TX_CLK_GATE_EN: when defined, txd_clk_o is parked at its
// idle level in IDLE; otherwise the baud counter and txd_clk_o free-run in IDLE.
// Handshake: rd_req_o is a one-clk strobe. rd_data_i must be valid on the clk that
// follows the strobe, and it is captured at the end of that clk.
module pcm_transmitter #(
    parameter int DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tx_en_i,
    input  logic        edge_i,
    input  logic [1:0]  number_i,
    input  logic [15:0] length_i,
    input  logic [31:0] code_i,
    input  logic [7:0]  rd_data_i,
    input  logic        empty_i,
    output logic        rd_req_o,
    output logic        txd_data_o,
    output logic        txd_clk_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        underflow_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;

    localparam logic [8:0] BAUD_LAST = 9'(2 * DIV - 1);
    localparam logic [8:0] BAUD_HALF = 9'(DIV);

    state_t      state_q, state_d;
    logic [8:0]  baud_q, baud_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] len_m1_q, len_m1_d;
    logic [31:0] code_q, code_d;
    logic        edge_q, edge_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  nxt_q, nxt_d;
    logic        pend_q, pend_d;
    logic        rd_req_q, rd_req_d;
    logic        txd_data_q, txd_data_d;
    logic        txd_clk_q, txd_clk_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        under_q, under_d;

    logic        last_byte;
    logic        start;
    logic [4:0]  sync_top;
    logic [4:0]  nb;

    // Next-state logic: bit sequencing, byte prefetch and frame start/end.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_cnt_d = byte_cnt_q;
        len_m1_d   = len_m1_q;
        code_d     = code_q;
        edge_d     = edge_q;
        byte_d     = byte_q;
        nxt_d      = nxt_q;
        pend_d     = rd_req_q;
        rd_req_d   = 1'b0;
        under_d    = 1'b0;
        done_d     = 1'b0;
        txd_data_d = txd_data_q;
        txd_clk_d  = txd_clk_q;
        busy_d     = busy_q;
        start      = 1'b0;
        last_byte  = (byte_cnt_q == len_m1_q);
        sync_top   = {~number_i, 3'b111};
        nb         = bit_q - 5'd1;

        // FIFO data arrives one clk after the strobe.
        if (pend_q) begin
            nxt_d = rd_data_i;
        end

        case (state_q)
            ST_IDLE: begin
                busy_d     = 1'b0;
                txd_data_d = 1'b1;
`ifdef PCM_TX_CLK_GATE_EN
                baud_d     = 9'd0;
                txd_clk_d  = ~edge_i;
`else
                baud_d = (baud_q == BAUD_LAST) ? 9'd0 : baud_q + 9'd1;
                if (baud_d == 9'd0) begin
                    txd_clk_d = ~edge_i;
                end else if (baud_d == BAUD_HALF) begin
                    txd_clk_d = edge_i;
                end
`endif
                if (tx_en_i) begin
                    start = 1'b1;
                end
            end
            default: begin
                // Prefetch at the start of the last bit of the sync word or of a non-final byte.
                if (baud_q == 9'd0 && bit_q == 5'd0 && (state_q == ST_SYNC || !last_byte)) begin
                    if (!empty_i) begin
                        rd_req_d = 1'b1;
                    end else begin
                        under_d = 1'b1;
                        nxt_d   = 8'hFF;
                    end
                end
                if (baud_q == BAUD_LAST) begin
                    baud_d    = 9'd0;
                    txd_clk_d = ~edge_q;
                    if (bit_q != 5'd0) begin
                        bit_d      = nb;
                        txd_data_d = (state_q == ST_SYNC) ? code_q[nb] : byte_q[nb[2:0]];
                    end else if (state_q == ST_SYNC || !last_byte) begin
                        state_d    = ST_DATA;
                        bit_d      = 5'd7;
                        byte_d     = nxt_q;
                        txd_data_d = nxt_q[7];
                        byte_cnt_d = (state_q == ST_SYNC) ? 16'd0 : byte_cnt_q + 16'd1;
                    end else begin
                        done_d = 1'b1;
                        if (tx_en_i) begin
                            start = 1'b1;
                        end else begin
                            state_d    = ST_IDLE;
                            busy_d     = 1'b0;
                            txd_data_d = 1'b1;
                            txd_clk_d  = ~edge_i;
                        end
                    end
                end else begin
                    baud_d = baud_q + 9'd1;
                    if (baud_d == BAUD_HALF) begin
                        txd_clk_d = edge_q;
                    end
                end
            end
        endcase

        // Frame start latches the configuration and presents the sync MSB immediately.
        if (start) begin
            state_d    = ST_SYNC;
            baud_d     = 9'd0;
            bit_d      = sync_top;
            code_d     = code_i;
            edge_d     = edge_i;
            len_m1_d   = (length_i == 16'd0) ? 16'd0 : length_i - 16'd1;
            byte_cnt_d = 16'd0;
            busy_d     = 1'b1;
            txd_clk_d  = ~edge_i;
            txd_data_d = code_i[sync_top];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            baud_q     <= 9'd0;
            bit_q      <= 5'd0;
            byte_cnt_q <= 16'd0;
            len_m1_q   <= 16'd0;
            code_q     <= 32'd0;
            edge_q     <= 1'b0;
            byte_q     <= 8'd0;
            nxt_q      <= 8'd0;
            pend_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            txd_data_q <= 1'b1;
            txd_clk_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_cnt_q <= byte_cnt_d;
            len_m1_q   <= len_m1_d;
            code_q     <= code_d;
            edge_q     <= edge_d;
            byte_q     <= byte_d;
            nxt_q      <= nxt_d;
            pend_q     <= pend_d;
            rd_req_q   <= rd_req_d;
            txd_data_q <= txd_data_d;
            txd_clk_q  <= txd_clk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            under_q    <= under_d;
        end
    end

    assign rd_req_o     = rd_req_q;
    assign txd_data_o   = txd_data_q;
    assign txd_clk_o    = txd_clk_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign underflow_o  = under_q;

endmodule
